// File: rtl/axi_bank_buffer.sv
// Per-bank elastic AXI buffering: one FIFO per channel plus an outstanding-burst limiter on AR and AW.
// Optional stall counters are compiled in when AXI_BANK_BUFFER_PERF_EN is defined.
module axi_bank_buffer #(
    parameter int AXI_DATA_WIDTH  = 512,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_TID_WIDTH   = 8,
    parameter int AXI_NUM_BANKS   = 1,
    parameter int REQ_DEPTH       = 2,
    parameter int RSP_DEPTH       = 4,
    parameter int MAX_OUTSTANDING = 16,
    localparam int AWW = AXI_ADDR_WIDTH + AXI_TID_WIDTH + 34,
    localparam int WW  = AXI_DATA_WIDTH + AXI_DATA_WIDTH / 8 + 1,
    localparam int BW  = AXI_TID_WIDTH + 2,
    localparam int RW  = AXI_DATA_WIDTH + AXI_TID_WIDTH + 3
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           s_awvalid      [AXI_NUM_BANKS],
    output logic           s_awready      [AXI_NUM_BANKS],
    input  logic [AWW-1:0] s_awdata       [AXI_NUM_BANKS],
    input  logic           s_wvalid       [AXI_NUM_BANKS],
    output logic           s_wready       [AXI_NUM_BANKS],
    input  logic [WW-1:0]  s_wdata        [AXI_NUM_BANKS],
    output logic           s_bvalid       [AXI_NUM_BANKS],
    input  logic           s_bready       [AXI_NUM_BANKS],
    output logic [BW-1:0]  s_bdata        [AXI_NUM_BANKS],
    input  logic           s_arvalid      [AXI_NUM_BANKS],
    output logic           s_arready      [AXI_NUM_BANKS],
    input  logic [AWW-1:0] s_ardata       [AXI_NUM_BANKS],
    output logic           s_rvalid       [AXI_NUM_BANKS],
    input  logic           s_rready       [AXI_NUM_BANKS],
    output logic [RW-1:0]  s_rdata        [AXI_NUM_BANKS],
    output logic           m_awvalid      [AXI_NUM_BANKS],
    input  logic           m_awready      [AXI_NUM_BANKS],
    output logic [AWW-1:0] m_awdata       [AXI_NUM_BANKS],
    output logic           m_wvalid       [AXI_NUM_BANKS],
    input  logic           m_wready       [AXI_NUM_BANKS],
    output logic [WW-1:0]  m_wdata        [AXI_NUM_BANKS],
    input  logic           m_bvalid       [AXI_NUM_BANKS],
    output logic           m_bready       [AXI_NUM_BANKS],
    input  logic [BW-1:0]  m_bdata        [AXI_NUM_BANKS],
    output logic           m_arvalid      [AXI_NUM_BANKS],
    input  logic           m_arready      [AXI_NUM_BANKS],
    output logic [AWW-1:0] m_ardata       [AXI_NUM_BANKS],
    input  logic           m_rvalid       [AXI_NUM_BANKS],
    output logic           m_rready       [AXI_NUM_BANKS],
    input  logic [RW-1:0]  m_rdata        [AXI_NUM_BANKS],
    output logic [7:0]     rd_outstanding [AXI_NUM_BANKS],
    output logic [7:0]     wr_outstanding [AXI_NUM_BANKS]
`ifdef AXI_BANK_BUFFER_PERF_EN
    ,
    output logic [31:0]    perf_ar_stall  [AXI_NUM_BANKS],
    output logic [31:0]    perf_aw_stall  [AXI_NUM_BANKS]
`endif
);

    localparam int QW = $clog2(REQ_DEPTH);
    localparam int QC = $clog2(REQ_DEPTH + 1);
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int PC = $clog2(RSP_DEPTH + 1);
    localparam logic [QC-1:0] QFULL = QC'(REQ_DEPTH);
    localparam logic [PC-1:0] PFULL = PC'(RSP_DEPTH);
    localparam logic [7:0]    MAXO  = 8'(MAX_OUTSTANDING);
    localparam int RLAST = AXI_TID_WIDTH + 2;

    function automatic logic [7:0] ost_next(input logic [7:0] cur, input logic inc, input logic dec);
        logic [7:0] nxt;
        nxt = cur;
        if (inc && !dec)
            nxt = cur + 8'd1;
        else if (dec && !inc && cur != 8'd0)
            nxt = cur - 8'd1;
        return nxt;
    endfunction

    for (genvar b = 0; b < AXI_NUM_BANKS; b++) begin : g_bank
        // Request group index: 0=AW, 1=W, 2=AR. Response group index: 0=B, 1=R.
        logic [QW-1:0]  rq_wp_q  [3];
        logic [QW-1:0]  rq_rp_q  [3];
        logic [QC-1:0]  rq_cnt_q [3];
        logic [QC-1:0]  rq_cnt_d [3];
        logic           rq_rdy_q [3];
        logic           rq_push  [3];
        logic           rq_pop   [3];
        logic [PW-1:0]  rs_wp_q  [2];
        logic [PW-1:0]  rs_rp_q  [2];
        logic [PC-1:0]  rs_cnt_q [2];
        logic [PC-1:0]  rs_cnt_d [2];
        logic           rs_rdy_q [2];
        logic           rs_push  [2];
        logic           rs_pop   [2];
        logic [AWW-1:0] aw_mem   [REQ_DEPTH];
        logic [WW-1:0]  w_mem    [REQ_DEPTH];
        logic [AWW-1:0] ar_mem   [REQ_DEPTH];
        logic [BW-1:0]  b_mem    [RSP_DEPTH];
        logic [RW-1:0]  r_mem    [RSP_DEPTH];
        logic [7:0]     rd_cnt_q, wr_cnt_q;
        logic           ar_ok, aw_ok, aw_v, w_v, ar_v, b_v, r_v;
        logic           rd_inc, rd_dec, wr_inc, wr_dec;

        assign ar_ok = rd_cnt_q < MAXO;
        assign aw_ok = wr_cnt_q < MAXO;
        assign aw_v  = (rq_cnt_q[0] != '0) && aw_ok;
        assign w_v   = rq_cnt_q[1] != '0;
        assign ar_v  = (rq_cnt_q[2] != '0) && ar_ok;
        assign b_v   = rs_cnt_q[0] != '0;
        assign r_v   = rs_cnt_q[1] != '0;

        always_comb begin
            rq_push[0] = s_awvalid[b] && rq_rdy_q[0];
            rq_push[1] = s_wvalid[b]  && rq_rdy_q[1];
            rq_push[2] = s_arvalid[b] && rq_rdy_q[2];
            rq_pop[0]  = aw_v && m_awready[b];
            rq_pop[1]  = w_v  && m_wready[b];
            rq_pop[2]  = ar_v && m_arready[b];
            rs_push[0] = m_bvalid[b] && rs_rdy_q[0];
            rs_push[1] = m_rvalid[b] && rs_rdy_q[1];
            rs_pop[0]  = b_v && s_bready[b];
            rs_pop[1]  = r_v && s_rready[b];
            for (int c = 0; c < 3; c++) begin
                rq_cnt_d[c] = rq_cnt_q[c];
                if (rq_push[c] && !rq_pop[c]) rq_cnt_d[c] = rq_cnt_q[c] + QC'(1);
                if (rq_pop[c] && !rq_push[c]) rq_cnt_d[c] = rq_cnt_q[c] - QC'(1);
            end
            for (int c = 0; c < 2; c++) begin
                rs_cnt_d[c] = rs_cnt_q[c];
                if (rs_push[c] && !rs_pop[c]) rs_cnt_d[c] = rs_cnt_q[c] + PC'(1);
                if (rs_pop[c] && !rs_push[c]) rs_cnt_d[c] = rs_cnt_q[c] - PC'(1);
            end
        end

        // Ready is !full of the next count, so it stays registered and free of m-side combinational paths.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                for (int c = 0; c < 3; c++) begin
                    rq_wp_q[c]  <= '0;
                    rq_rp_q[c]  <= '0;
                    rq_cnt_q[c] <= '0;
                    rq_rdy_q[c] <= 1'b0;
                end
                for (int c = 0; c < 2; c++) begin
                    rs_wp_q[c]  <= '0;
                    rs_rp_q[c]  <= '0;
                    rs_cnt_q[c] <= '0;
                    rs_rdy_q[c] <= 1'b0;
                end
            end else begin
                for (int c = 0; c < 3; c++) begin
                    if (rq_push[c]) rq_wp_q[c] <= rq_wp_q[c] + QW'(1);
                    if (rq_pop[c])  rq_rp_q[c] <= rq_rp_q[c] + QW'(1);
                    rq_cnt_q[c] <= rq_cnt_d[c];
                    rq_rdy_q[c] <= rq_cnt_d[c] != QFULL;
                end
                for (int c = 0; c < 2; c++) begin
                    if (rs_push[c]) rs_wp_q[c] <= rs_wp_q[c] + PW'(1);
                    if (rs_pop[c])  rs_rp_q[c] <= rs_rp_q[c] + PW'(1);
                    rs_cnt_q[c] <= rs_cnt_d[c];
                    rs_rdy_q[c] <= rs_cnt_d[c] != PFULL;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rq_push[0]) aw_mem[rq_wp_q[0]] <= s_awdata[b];
            if (rq_push[1]) w_mem[rq_wp_q[1]]  <= s_wdata[b];
            if (rq_push[2]) ar_mem[rq_wp_q[2]] <= s_ardata[b];
            if (rs_push[0]) b_mem[rs_wp_q[0]]  <= m_bdata[b];
            if (rs_push[1]) r_mem[rs_wp_q[1]]  <= m_rdata[b];
        end

        assign rd_inc = rq_pop[2];
        assign rd_dec = rs_pop[1] && r_mem[rs_rp_q[1]][RLAST];
        assign wr_inc = rq_pop[0];
        assign wr_dec = rs_pop[0];

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                rd_cnt_q <= 8'd0;
                wr_cnt_q <= 8'd0;
            end else begin
                if (rd_dec && !rd_inc) assert (rd_cnt_q != 8'd0);
                if (wr_dec && !wr_inc) assert (wr_cnt_q != 8'd0);
                rd_cnt_q <= ost_next(rd_cnt_q, rd_inc, rd_dec);
                wr_cnt_q <= ost_next(wr_cnt_q, wr_inc, wr_dec);
            end
        end

`ifdef AXI_BANK_BUFFER_PERF_EN
        logic [31:0] ar_stall_q, aw_stall_q;
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                ar_stall_q <= '0;
                aw_stall_q <= '0;
            end else begin
                if (rq_cnt_q[2] != '0 && !ar_ok && ar_stall_q != '1) ar_stall_q <= ar_stall_q + 32'd1;
                if (rq_cnt_q[0] != '0 && !aw_ok && aw_stall_q != '1) aw_stall_q <= aw_stall_q + 32'd1;
            end
        end
        assign perf_ar_stall[b] = ar_stall_q;
        assign perf_aw_stall[b] = aw_stall_q;
`endif

        assign s_awready[b]      = rq_rdy_q[0];
        assign s_wready[b]       = rq_rdy_q[1];
        assign s_arready[b]      = rq_rdy_q[2];
        assign m_bready[b]       = rs_rdy_q[0];
        assign m_rready[b]       = rs_rdy_q[1];
        assign m_awvalid[b]      = aw_v;
        assign m_wvalid[b]       = w_v;
        assign m_arvalid[b]      = ar_v;
        assign s_bvalid[b]       = b_v;
        assign s_rvalid[b]       = r_v;
        assign m_awdata[b]       = aw_mem[rq_rp_q[0]];
        assign m_wdata[b]        = w_mem[rq_rp_q[1]];
        assign m_ardata[b]       = ar_mem[rq_rp_q[2]];
        assign s_bdata[b]        = b_mem[rs_rp_q[0]];
        assign s_rdata[b]        = r_mem[rs_rp_q[1]];
        assign rd_outstanding[b] = rd_cnt_q;
        assign wr_outstanding[b] = wr_cnt_q;
    end

endmodule

// File: tb/tb_axi_bank_buffer.sv
// Directed-plus-random bench for axi_bank_buffer: two banks, 32-bit data, limiter of 2 bursts.
module tb_axi_bank_buffer;
    localparam int D = 32, NB = 2, MAXO = 2;
    localparam int AWW = 32 + 8 + 34, WW = D + D / 8 + 1, BW = 8 + 2, RW = D + 8 + 3;

    logic clk = 1'b0, reset_n = 1'b0;
    logic s_awvalid [NB], s_awready [NB], s_wvalid [NB], s_wready [NB];
    logic s_bvalid [NB], s_bready [NB], s_arvalid [NB], s_arready [NB];
    logic s_rvalid [NB], s_rready [NB];
    logic m_awvalid [NB], m_awready [NB], m_wvalid [NB], m_wready [NB];
    logic m_bvalid [NB], m_bready [NB], m_arvalid [NB], m_arready [NB];
    logic m_rvalid [NB], m_rready [NB];
    logic [AWW-1:0] s_awdata [NB], s_ardata [NB], m_awdata [NB], m_ardata [NB];
    logic [WW-1:0]  s_wdata [NB], m_wdata [NB];
    logic [BW-1:0]  s_bdata [NB], m_bdata [NB];
    logic [RW-1:0]  s_rdata [NB], m_rdata [NB];
    logic [7:0]     rd_outstanding [NB], wr_outstanding [NB];
`ifdef AXI_BANK_BUFFER_PERF_EN
    logic [31:0]    perf_ar_stall [NB], perf_aw_stall [NB];
`endif

    axi_bank_buffer #(
        .AXI_DATA_WIDTH(D), .AXI_ADDR_WIDTH(32), .AXI_TID_WIDTH(8), .AXI_NUM_BANKS(NB),
        .REQ_DEPTH(2), .RSP_DEPTH(4), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awdata(s_awdata),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bdata(s_bdata),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ardata(s_ardata),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awdata(m_awdata),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bdata(m_bdata),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_ardata(m_ardata),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
        .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding)
`ifdef AXI_BANK_BUFFER_PERF_EN
        , .perf_ar_stall(perf_ar_stall), .perf_aw_stall(perf_aw_stall)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int rd_model [NB];
    int wr_model [NB];
    int done1;
    logic [AWW-1:0] ax_q [$];
    logic [RW-1:0]  r_q [$];
    logic [AWW-1:0] p0, p1, p2, p3, aw_exp;
    logic [RW-1:0]  rb, ra, rbb, bank0_head;
    logic [BW-1:0]  bb;
    logic [WW-1:0]  wb;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [AWW-1:0] mk_ax(input logic [31:0] addr, input logic [7:0] id, input logic [7:0] len);
        return {addr, id, len, 26'($urandom)};
    endfunction

    function automatic logic [RW-1:0] mk_r(input logic last, input logic [7:0] id);
        return {32'($urandom), last, id, 2'($urandom)};
    endfunction

    // Outstanding model: bursts issued minus bursts completed, never below zero.
    function automatic int dec0(input int v);
        return (v > 0) ? v - 1 : 0;
    endfunction

    initial begin
        for (int b = 0; b < NB; b++) begin
            s_awvalid[b] = 0; s_wvalid[b] = 0; s_arvalid[b] = 0; s_bready[b] = 1; s_rready[b] = 1;
            m_awready[b] = 0; m_wready[b] = 0; m_arready[b] = 0; m_bvalid[b] = 0; m_rvalid[b] = 0;
            s_awdata[b] = '0; s_wdata[b] = '0; s_ardata[b] = '0; m_bdata[b] = '0; m_rdata[b] = '0;
            rd_model[b] = 0; wr_model[b] = 0;
        end
        repeat (3) cyc();
        chk("rst_awready", 128'(s_awready[0]), 128'(0));
        chk("rst_arready1", 128'(s_arready[1]), 128'(0));
        chk("rst_m_arvalid", 128'(m_arvalid[0]), 128'(0));
        chk("rst_s_rvalid", 128'(s_rvalid[0]), 128'(0));
        chk("rst_rd_out", 128'(rd_outstanding[0]), 128'(0));
        chk("rst_wr_out1", 128'(wr_outstanding[1]), 128'(0));
        reset_n = 1;
        cyc();
        chk("rel_awready", 128'(s_awready[0]), 128'(1));
        chk("rel_wready", 128'(s_wready[0]), 128'(1));
        chk("rel_arready1", 128'(s_arready[1]), 128'(1));
        chk("rel_bready", 128'(m_bready[0]), 128'(1));
        chk("rel_rready1", 128'(m_rready[1]), 128'(1));

        // Single AR burst of 4 beats
        p0 = mk_ax(32'h1000, 8'd3, 8'd3);
        s_arvalid[0] = 1; s_ardata[0] = p0;
        cyc();
        s_arvalid[0] = 0;
        chk("t1_arvalid", 128'(m_arvalid[0]), 128'(1));
        chk("t1_ardata", 128'(m_ardata[0]), 128'(p0));
        chk("t1_out0", 128'(rd_outstanding[0]), 128'(rd_model[0]));
        m_arready[0] = 1;
        cyc();
        rd_model[0]++;
        m_arready[0] = 0;
        chk("t1_out1", 128'(rd_outstanding[0]), 128'(rd_model[0]));
        chk("t1_arvalid_done", 128'(m_arvalid[0]), 128'(0));
        for (int i = 0; i < 4; i++) r_q.push_back(mk_r(i == 3, 8'd3));
        for (int i = 0; i < 4; i++) begin
            rb = r_q.pop_front();
            m_rvalid[0] = 1; m_rdata[0] = rb;
            cyc();
            m_rvalid[0] = 0;
            chk($sformatf("t1_rvalid%0d", i), 128'(s_rvalid[0]), 128'(1));
            chk($sformatf("t1_rdata%0d", i), 128'(s_rdata[0]), 128'(rb));
            chk($sformatf("t1_rout%0d", i), 128'(rd_outstanding[0]), 128'(rd_model[0]));
            cyc();
            if (rb[8+2]) rd_model[0] = dec0(rd_model[0]);
        end
        chk("t1_out_end", 128'(rd_outstanding[0]), 128'(rd_model[0]));

        // Limiter of 2: third AR held until one read completes
        p0 = mk_ax($urandom, 8'd10, 8'd0); p1 = mk_ax($urandom, 8'd11, 8'd0); p2 = mk_ax($urandom, 8'd12, 8'd0);
        m_arready[0] = 1;
        s_arvalid[0] = 1; s_ardata[0] = p0;
        cyc();
        s_ardata[0] = p1;
        chk("t2_ar0", 128'(m_ardata[0]), 128'(p0));
        chk("t2_arv0", 128'(m_arvalid[0]), 128'(1));
        cyc();
        rd_model[0]++;
        s_ardata[0] = p2;
        chk("t2_ar1", 128'(m_ardata[0]), 128'(p1));
        chk("t2_out1", 128'(rd_outstanding[0]), 128'(rd_model[0]));
        cyc();
        rd_model[0]++;
        s_arvalid[0] = 0;
        chk("t2_out2", 128'(rd_outstanding[0]), 128'(rd_model[0]));
        chk("t2_held", 128'(m_arvalid[0]), 128'(0));
        cyc(); cyc();
        chk("t2_still_held", 128'(m_arvalid[0]), 128'(0));
        rb = mk_r(1'b1, 8'd10);
        m_rvalid[0] = 1; m_rdata[0] = rb;
        cyc();
        m_rvalid[0] = 0;
        chk("t2_rdata", 128'(s_rdata[0]), 128'(rb));
        chk("t2_held_r", 128'(m_arvalid[0]), 128'(0));
        cyc();
        rd_model[0] = dec0(rd_model[0]);
        chk("t2_out_after_r", 128'(rd_outstanding[0]), 128'(rd_model[0]));
        chk("t2_issue", 128'(m_arvalid[0]), 128'(1));
        chk("t2_ar2", 128'(m_ardata[0]), 128'(p2));
        cyc();
        rd_model[0]++;
        chk("t2_out_full", 128'(rd_outstanding[0]), 128'(rd_model[0]));

        // Issue and completion on the same edge leave the count unchanged
        p3 = mk_ax($urandom, 8'd13, 8'd0);
        s_arvalid[0] = 1; s_ardata[0] = p3;
        cyc();
        s_arvalid[0] = 0;
        chk("t4_held", 128'(m_arvalid[0]), 128'(0));
        ra = mk_r(1'b1, 8'd11); rbb = mk_r(1'b1, 8'd12);
        m_rvalid[0] = 1; m_rdata[0] = ra;
        cyc();
        m_rdata[0] = rbb;
        chk("t4_rA", 128'(s_rdata[0]), 128'(ra));
        cyc();
        rd_model[0] = dec0(rd_model[0]);
        m_rvalid[0] = 0;
        chk("t4_out1", 128'(rd_outstanding[0]), 128'(rd_model[0]));
        chk("t4_arv", 128'(m_arvalid[0]), 128'(1));
        chk("t4_ar3", 128'(m_ardata[0]), 128'(p3));
        chk("t4_rB", 128'(s_rdata[0]), 128'(rbb));
        cyc();
        rd_model[0] = dec0(rd_model[0] + 1);
        chk("t4_same_edge", 128'(rd_outstanding[0]), 128'(rd_model[0]));
        chk("t4_ar_empty", 128'(m_arvalid[0]), 128'(0));
        chk("t4_r_empty", 128'(s_rvalid[0]), 128'(0));
        m_arready[0] = 0;

        // AW backpressure with a 2-entry FIFO, then in-order drain
        ax_q.push_back(mk_ax($urandom, 8'd1, 8'd0));
        ax_q.push_back(mk_ax($urandom, 8'd2, 8'd0));
        s_awvalid[0] = 1; s_awdata[0] = ax_q[0];
        cyc();
        s_awdata[0] = ax_q[1];
        cyc();
        s_awvalid[0] = 0;
        chk("t3_full", 128'(s_awready[0]), 128'(0));
        chk("t3_awv", 128'(m_awvalid[0]), 128'(1));
        aw_exp = ax_q.pop_front();
        chk("t3_aw_id1", 128'(m_awdata[0]), 128'(aw_exp));
        m_awready[0] = 1;
        cyc();
        wr_model[0]++;
        aw_exp = ax_q.pop_front();
        chk("t3_aw_id2", 128'(m_awdata[0]), 128'(aw_exp));
        chk("t3_ready_back", 128'(s_awready[0]), 128'(1));
        chk("t3_wout1", 128'(wr_outstanding[0]), 128'(wr_model[0]));
        cyc();
        wr_model[0]++;
        m_awready[0] = 0;
        chk("t3_drained", 128'(m_awvalid[0]), 128'(0));
        chk("t3_wout2", 128'(wr_outstanding[0]), 128'(wr_model[0]));
        for (int j = 0; j < 2; j++) begin
            bb = {8'(j + 1), 2'($urandom)};
            m_bvalid[0] = 1; m_bdata[0] = bb;
            cyc();
            m_bvalid[0] = 0;
            chk($sformatf("t3_bvalid%0d", j), 128'(s_bvalid[0]), 128'(1));
            chk($sformatf("t3_bdata%0d", j), 128'(s_bdata[0]), 128'(bb));
            cyc();
            wr_model[0] = dec0(wr_model[0]);
            chk($sformatf("t3_wout_b%0d", j), 128'(wr_outstanding[0]), 128'(wr_model[0]));
        end

        // Bank 0 R FIFO filled and stalled; bank 1 runs 8 reads independently
        s_rready[0] = 0;
        for (int i = 0; i < 4; i++) begin
            rb = mk_r(1'b0, 8'd20);
            if (i == 0) bank0_head = rb;
            m_rvalid[0] = 1; m_rdata[0] = rb;
            cyc();
        end
        m_rvalid[0] = 0;
        chk("t5_b0_rready", 128'(m_rready[0]), 128'(0));
        m_arready[1] = 1;
        done1 = 0;
        for (int i = 0; i < 8; i++) begin
            p0 = mk_ax($urandom, 8'(i), 8'd0);
            s_arvalid[1] = 1; s_ardata[1] = p0;
            cyc();
            s_arvalid[1] = 0;
            chk($sformatf("t5_ar%0d", i), 128'({m_arvalid[1], m_ardata[1]}), 128'({1'b1, p0}));
            cyc();
            rd_model[1]++;
            chk($sformatf("t5_out%0d", i), 128'(rd_outstanding[1]), 128'(rd_model[1]));
            rb = mk_r(1'b1, 8'(i));
            m_rvalid[1] = 1; m_rdata[1] = rb;
            cyc();
            m_rvalid[1] = 0;
            chk($sformatf("t5_r%0d", i), 128'(s_rdata[1]), 128'(rb));
            if (s_rvalid[1]) done1++;
            cyc();
            rd_model[1] = dec0(rd_model[1]);
        end
        chk("t5_done", 128'(done1), 128'(8));
        chk("t5_out_end", 128'(rd_outstanding[1]), 128'(rd_model[1]));
        chk("t5_b0_still", 128'(m_rready[0]), 128'(0));
        chk("t5_b0_head", 128'(s_rdata[0]), 128'(bank0_head));

        // Reset in the middle of a write burst
        aw_exp = mk_ax($urandom, 8'd5, 8'd3);
        s_awvalid[0] = 1; s_awdata[0] = aw_exp;
        cyc();
        s_awvalid[0] = 0;
        for (int i = 0; i < 2; i++) begin
            s_wvalid[0] = 1; s_wdata[0] = {32'($urandom), 4'hF, 1'b0};
            cyc();
        end
        s_wvalid[0] = 0;
        chk("t6_pre_awv", 128'(m_awvalid[0]), 128'(1));
        chk("t6_pre_wv", 128'(m_wvalid[0]), 128'(1));
        reset_n = 0;
        cyc();
        for (int b = 0; b < NB; b++) begin rd_model[b] = 0; wr_model[b] = 0; end
        chk("t6_awv", 128'(m_awvalid[0]), 128'(0));
        chk("t6_wv", 128'(m_wvalid[0]), 128'(0));
        chk("t6_rv", 128'(s_rvalid[0]), 128'(0));
        chk("t6_awready", 128'(s_awready[0]), 128'(0));
        chk("t6_rout", 128'(rd_outstanding[0]), 128'(rd_model[0]));
        chk("t6_wout", 128'(wr_outstanding[0]), 128'(wr_model[0]));
        reset_n = 1;
        s_rready[0] = 1;
        cyc();
        chk("t6_awready_back", 128'(s_awready[0]), 128'(1));
        chk("t6_rready_back", 128'(m_rready[0]), 128'(1));
        m_wready[0] = 1; m_awready[0] = 1;
        for (int i = 0; i < 4; i++) begin
            wb = {32'($urandom), 4'($urandom), i == 3};
            s_wvalid[0] = 1; s_wdata[0] = wb;
            cyc();
            s_wvalid[0] = 0;
            chk($sformatf("t6_w%0d", i), 128'({m_wvalid[0], m_wdata[0]}), 128'({1'b1, wb}));
            cyc();
        end
        aw_exp = mk_ax($urandom, 8'd6, 8'd3);
        s_awvalid[0] = 1; s_awdata[0] = aw_exp;
        cyc();
        s_awvalid[0] = 0;
        chk("t6_aw", 128'({m_awvalid[0], m_awdata[0]}), 128'({1'b1, aw_exp}));
        cyc();
        wr_model[0]++;
        chk("t6_wout1", 128'(wr_outstanding[0]), 128'(wr_model[0]));
        bb = {8'd6, 2'b00};
        m_bvalid[0] = 1; m_bdata[0] = bb;
        cyc();
        m_bvalid[0] = 0;
        chk("t6_b", 128'({s_bvalid[0], s_bdata[0]}), 128'({1'b1, bb}));
        cyc();
        wr_model[0] = dec0(wr_model[0]);
        chk("t6_wout0", 128'(wr_outstanding[0]), 128'(wr_model[0]));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/axi_bank_buffer.md
Name: axi_bank_buffer

Overview:
- Per-bank elastic buffering between the Vortex memory-side AXI master and the platform AXI slaves.
- Each bank has five channels (AW, W, B, AR, R), each carried as a packed struct payload, and each channel gets its own parametrised FIFO.
- A per-bank outstanding-burst limiter throttles AR and AW independently.
- Sits between the cache/memory arbiter output and the board memory ports.

Parameters:
- AXI_DATA_WIDTH, 512, data bus width in bits (multiple of 8).
- AXI_ADDR_WIDTH, 32, address width.
- AXI_TID_WIDTH, 8, transaction ID width.
- AXI_NUM_BANKS, 1, number of independent banks.
- REQ_DEPTH, 2, AW/W/AR FIFO entries (power of 2, >=2).
- RSP_DEPTH, 4, B/R FIFO entries (power of 2, >=2).
- MAX_OUTSTANDING, 16, maximum in-flight read bursts per bank, and separately maximum in-flight write bursts per bank (1..255).

Ports:
Widths: AWW = AXI_ADDR_WIDTH + AXI_TID_WIDTH + 34; WW = AXI_DATA_WIDTH + AXI_DATA_WIDTH/8 + 1; BW = AXI_TID_WIDTH + 2; RW = AXI_DATA_WIDTH + AXI_TID_WIDTH + 3. "[NB]" means an unpacked array of AXI_NUM_BANKS elements.
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- s_awvalid/s_awready  in/out  1[NB]  upstream AW handshake
- s_awdata  in  AWW[NB]  {addr,id,len,size,burst,lock,cache,prot,qos,region}
- s_wvalid/s_wready  in/out  1[NB]  upstream W handshake
- s_wdata  in  WW[NB]  {data,strb,last}
- s_bvalid/s_bready  out/in  1[NB]  upstream B handshake
- s_bdata  out  BW[NB]  {id,resp}
- s_arvalid/s_arready  in/out  1[NB]  upstream AR handshake
- s_ardata  in  AWW[NB]  same layout as AW
- s_rvalid/s_rready  out/in  1[NB]  upstream R handshake
- s_rdata  out  RW[NB]  {data,last,id,resp}
- m_*  mirror set of all s_* ports, directions reversed, facing memory
- rd_outstanding  out  8[NB]  current read-burst count per bank
- wr_outstanding  out  8[NB]  current write-burst count per bank

Behaviour:
- Reset: all FIFOs empty; every s_*valid, m_*valid and counter is 0; s_*ready is 0 during reset and rises the first cycle after reset_n=1.
- FIFO: transfer on valid&&ready. Data comes from registered storage. Latency s-side to m-side is exactly 1 cycle; the same applies to responses.
- Ready is registered as !full. A simultaneous push and pop on a full FIFO is not allowed (ready is already 0).
- Pointers wrap modulo depth; a count register distinguishes full from empty.
- No combinational path from m_*ready to s_*ready, or from s_*valid to m_*valid.
- AR gating: m_arvalid = ar_fifo_nonempty && rd_outstanding < MAX_OUTSTANDING.
  - Increment on m_ar handshake.
  - Decrement on s_r handshake with last=1.
  - Both in the same cycle: unchanged.
  - Counter never wraps. A decrement at 0 is an assertion failure and is ignored.
- AW gating is identical, using wr_outstanding. Increment on m_aw handshake; decrement on s_b handshake.
- W channel is not gated by AW, so write data may lead its address.
- Payload passes through bit-exact; no field is modified.
- Banks are fully independent; there is no cross-bank ordering.
- Reset mid-burst: all in-flight state is discarded and counters are cleared. Downstream is expected to be reset in the same cycle.

Optional Feature:
- Macro: AXI_BANK_BUFFER_PERF_EN.
- With the macro: adds outputs perf_ar_stall[NB] and perf_aw_stall[NB], 32 bits each. Each is a saturating count of cycles where the FIFO is non-empty but issue is blocked by the limiter.
  - Cleared by reset.
  - Holds at 0xFFFFFFFF once saturated.
- Without the macro: the ports are absent and no counter logic exists.

Test Plan:
- Single bank, AR addr=0x1000, id=3, len=3 → m_arvalid one cycle later with identical payload; 4 R beats with last on the 4th → rd_outstanding goes 0→1→0, and s_rdata matches beat-for-beat.
- MAX_OUTSTANDING=2: three back-to-back ARs, no R → third AR held (m_arvalid=0) until the first R last handshake, then issued the next cycle.
- REQ_DEPTH=2 with m_awready=0: push AWs → s_awready=0 after 2 accepted; release m_awready → drains in order with IDs 1,2, and s_awready returns to 1.
- Same-cycle m_ar handshake and R last handshake at rd_outstanding=1 → count stays 1.
- AXI_NUM_BANKS=2: bank0 m_rready stuck at 0 while bank1 runs 8 reads → bank1 completes all 8 unaffected.
- reset_n=0 for 1 cycle mid-write-burst (2 of 4 W beats sent) → all valids 0, counters 0; after release, a fresh burst completes normally.
